// File: rtl/pcie_msix_rx.sv
// pcie_msix_rx: decodes inbound MSI-X doorbell memory-write TLPs into interrupt
// vector indices, queued in a small FIFO and presented on an AXI-Stream source.
// Optional statistics counters are built only when MSIX_RX_STATS_EN is defined;
// otherwise the stat outputs are tied to zero.
module pcie_msix_rx #(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TLP_SEG_DATA_W = 64,
    parameter int unsigned HDR_W          = 128,
    parameter int unsigned IRQ_INDEX_W    = 11,
    parameter int unsigned ID_W           = 8,
    parameter int unsigned DEST_W         = 8,
    parameter int unsigned USER_W         = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [TLP_SEG_DATA_W-1:0]      i_rx_req_tlp_data,
    input  logic [HDR_W-1:0]               i_rx_req_tlp_hdr,
    input  logic                           i_rx_req_tlp_valid,
    input  logic                           i_rx_req_tlp_sop,
    input  logic                           i_rx_req_tlp_eop,
    output logic                           o_rx_req_tlp_ready,
    output logic [IRQ_INDEX_W-1:0]         o_m_axis_irq_tdata,
    output logic [(IRQ_INDEX_W+7)/8-1:0]   o_m_axis_irq_tkeep,
    output logic                           o_m_axis_irq_tvalid,
    input  logic                           i_m_axis_irq_tready,
    output logic                           o_m_axis_irq_tlast,
    output logic [ID_W-1:0]                o_m_axis_irq_tid,
    output logic [DEST_W-1:0]              o_m_axis_irq_tdest,
    output logic [USER_W-1:0]              o_m_axis_irq_tuser,
    input  logic [63:0]                    i_msix_addr,
    input  logic                           i_enable,
    output logic [31:0]                    o_stat_irq_count,
    output logic [31:0]                    o_stat_drop_count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    // Elaboration-time parameter legality
    if (HDR_W != 128) begin : g_bad_hdr_w
        $fatal(1, "pcie_msix_rx: HDR_W must be 128");
    end
    if (TLP_SEG_DATA_W < 32) begin : g_bad_data_w
        $fatal(1, "pcie_msix_rx: TLP_SEG_DATA_W must be at least 32");
    end
    if (IRQ_INDEX_W < 1 || IRQ_INDEX_W > 11) begin : g_bad_irq_w
        $fatal(1, "pcie_msix_rx: IRQ_INDEX_W must be 1..11");
    end
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 64 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "pcie_msix_rx: FIFO_DEPTH must be a power of 2 in 2..64");
    end

    typedef enum logic [0:0] {ST_IDLE, ST_DRAIN} state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   r_ready;
    logic                   r_tvalid;
    logic [IRQ_INDEX_W-1:0] r_tdata;
    logic [IRQ_INDEX_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]          r_wr_ptr;
    logic [AW-1:0]          r_rd_ptr;
    logic [CW-1:0]          r_count;
    logic [CW-1:0]          w_count_next;
    logic [AW-1:0]          w_rd_nxt;

    logic                   w_beat;
    logic                   w_is_3dw;
    logic                   w_is_4dw;
    logic [61:0]            w_addr;
    logic                   w_hdr_hit;
    logic                   w_vec_ok;
    logic [IRQ_INDEX_W-1:0] w_vec;
    logic                   w_push;
    logic                   w_drop;
    logic                   w_pop;
    logic                   w_unused;

    // Header decode for the beat currently on the bus
    assign w_is_3dw  = (i_rx_req_tlp_hdr[127:125] == 3'b010);
    assign w_is_4dw  = (i_rx_req_tlp_hdr[127:125] == 3'b011);
    assign w_addr    = w_is_3dw ? {32'd0, i_rx_req_tlp_hdr[63:34]} : i_rx_req_tlp_hdr[63:2];
    assign w_hdr_hit = i_enable && (w_is_3dw || w_is_4dw)
                    && (i_rx_req_tlp_hdr[124:120] == 5'd0)
                    && (i_rx_req_tlp_hdr[105:96] == 10'd1)
                    && (i_rx_req_tlp_hdr[67:64] == 4'hF)
                    && (w_addr == i_msix_addr[63:2]);
    assign w_vec_ok  = (i_rx_req_tlp_data[31:IRQ_INDEX_W] == '0);
    assign w_vec     = i_rx_req_tlp_data[IRQ_INDEX_W-1:0];
    assign w_beat    = i_rx_req_tlp_valid && r_ready;
    assign w_pop     = r_tvalid && i_m_axis_irq_tready;
    assign w_rd_nxt  = r_rd_ptr + AW'(1);
    assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);

    // Bits that carry no decode meaning for this block
    assign w_unused = ^{i_msix_addr[1:0], i_rx_req_tlp_hdr, i_rx_req_tlp_data, w_drop};

    // TLP framing state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    // Next state and per-TLP push/drop decision, taken on the sop beat only
    always_comb begin
        w_state_next = r_state;
        w_push       = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_beat && i_rx_req_tlp_sop) begin
                    if (w_hdr_hit && w_vec_ok) w_push = 1'b1;
                    else                       w_drop = 1'b1;
                    if (!i_rx_req_tlp_eop) w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_beat && i_rx_req_tlp_eop) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // FIFO bookkeeping, registered head entry, tvalid and sink ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_tvalid <= 1'b0;
            r_tdata  <= '0;
            r_ready  <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= w_rd_nxt;
            r_count  <= w_count_next;
            r_tvalid <= (w_count_next != '0);
            r_ready  <= (w_state_next == ST_DRAIN) || (w_count_next != CW'(FIFO_DEPTH));
            if (w_pop) begin
                if (r_count > CW'(1)) r_tdata <= r_mem[w_rd_nxt];
                else if (w_push)      r_tdata <= w_vec;
            end else if (r_count == '0 && w_push) begin
                r_tdata <= w_vec;
            end
        end
    end

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_vec;
    end

    assign o_rx_req_tlp_ready  = r_ready;
    assign o_m_axis_irq_tvalid = r_tvalid;
    assign o_m_axis_irq_tdata  = r_tdata;
    assign o_m_axis_irq_tkeep  = '1;
    assign o_m_axis_irq_tlast  = 1'b1;
    assign o_m_axis_irq_tid    = '0;
    assign o_m_axis_irq_tdest  = '0;
    assign o_m_axis_irq_tuser  = '0;

`ifdef MSIX_RX_STATS_EN
    logic [31:0] r_irq_count;
    logic [31:0] r_drop_count;

    // Push and drop statistics, wrapping at 2**32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq_count  <= 32'd0;
            r_drop_count <= 32'd0;
        end else begin
            if (w_push) r_irq_count  <= r_irq_count + 32'd1;
            if (w_drop) r_drop_count <= r_drop_count + 32'd1;
        end
    end

    assign o_stat_irq_count  = r_irq_count;
    assign o_stat_drop_count = r_drop_count;
`else
    assign o_stat_irq_count  = 32'd0;
    assign o_stat_drop_count = 32'd0;
`endif

endmodule

// File: tb/tb_pcie_msix_rx.sv
// Scoreboard bench for pcie_msix_rx: the driver predicts each accepted TLP's
// outcome from the decode rules and queues expected vectors; a monitor pops
// and compares on every tvalid && tready.
`timescale 1ns/1ps
module tb_pcie_msix_rx;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned IW    = 11;
    localparam int unsigned DW    = 64;
    localparam int unsigned HW    = 128;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DW-1:0]     tlp_data = '0;
    logic [HW-1:0]     tlp_hdr = '0;
    logic              tlp_valid = 1'b0;
    logic              tlp_sop = 1'b0;
    logic              tlp_eop = 1'b0;
    logic              tlp_ready;
    logic [IW-1:0]     irq_tdata;
    logic [1:0]        irq_tkeep;
    logic              irq_tvalid;
    logic              irq_tready = 1'b0;
    logic              irq_tlast;
    logic [7:0]        irq_tid;
    logic [7:0]        irq_tdest;
    logic [0:0]        irq_tuser;
    logic [63:0]       msix_addr = '0;
    logic              enable = 1'b0;
    logic [31:0]       stat_irq;
    logic [31:0]       stat_drop;

    int                n_tests = 0;
    int                n_fail = 0;
    logic [IW-1:0]     sb_q[$];
    logic [31:0]       exp_irq = 0;
    logic [31:0]       exp_drop = 0;
    bit                rand_rdy = 0;

    pcie_msix_rx #(.FIFO_DEPTH(DEPTH), .TLP_SEG_DATA_W(DW), .HDR_W(HW), .IRQ_INDEX_W(IW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_rx_req_tlp_data(tlp_data), .i_rx_req_tlp_hdr(tlp_hdr),
        .i_rx_req_tlp_valid(tlp_valid), .i_rx_req_tlp_sop(tlp_sop),
        .i_rx_req_tlp_eop(tlp_eop), .o_rx_req_tlp_ready(tlp_ready),
        .o_m_axis_irq_tdata(irq_tdata), .o_m_axis_irq_tkeep(irq_tkeep),
        .o_m_axis_irq_tvalid(irq_tvalid), .i_m_axis_irq_tready(irq_tready),
        .o_m_axis_irq_tlast(irq_tlast), .o_m_axis_irq_tid(irq_tid),
        .o_m_axis_irq_tdest(irq_tdest), .o_m_axis_irq_tuser(irq_tuser),
        .i_msix_addr(msix_addr), .i_enable(enable),
        .o_stat_irq_count(stat_irq), .o_stat_drop_count(stat_drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_stats(input string tag);
`ifdef MSIX_RX_STATS_EN
        chk({tag, "_irq_count"}, stat_irq, exp_irq);
        chk({tag, "_drop_count"}, stat_drop, exp_drop);
`else
        chk({tag, "_irq_count"}, stat_irq, 0);
        chk({tag, "_drop_count"}, stat_drop, 0);
`endif
    endtask

    // Reference decode: byte address compared at dword granularity
    function automatic bit ref_hit(input bit en, input logic [127:0] h, input logic [63:0] maddr);
        longint unsigned a;
        if (!en) return 0;
        if (h[127:125] == 3'd2)      a = {32'h0, h[63:32]};
        else if (h[127:125] == 3'd3) a = h[63:0];
        else return 0;
        if (h[124:120] != 0 || h[105:96] != 1 || h[67:64] != 4'hF) return 0;
        return (a >> 2) == (maddr >> 2);
    endfunction

    function automatic logic [127:0] mk_hdr(input logic [2:0] fmt, input logic [4:0] ty,
                                            input logic [9:0] len, input logic [3:0] be,
                                            input logic [63:0] a);
        logic [127:0] h;
        h = {$urandom, $urandom, $urandom, $urandom};
        h[127:125] = fmt;
        h[124:120] = ty;
        h[105:96]  = len;
        h[67:64]   = be;
        if (fmt == 3'b011) h[63:2]  = a[63:2];
        else               h[63:34] = a[31:2];
        return h;
    endfunction

    // Present one beat until accepted or the cycle bound runs out
    task automatic drive_beat(input bit p_sop, input bit p_eop, input logic [127:0] h,
                              input logic [63:0] d, input int bound, output bit acc);
        int n = 0;
        acc = 0;
        tlp_valid = 1'b1; tlp_sop = p_sop; tlp_eop = p_eop; tlp_hdr = h; tlp_data = d;
        forever begin
            @(negedge clk);
            if (tlp_ready) begin
                @(posedge clk); #1;
                acc = 1;
                break;
            end
            n++;
            if (n >= bound) begin
                @(posedge clk); #1;
                break;
            end
        end
        tlp_valid = 1'b0; tlp_sop = 1'b0; tlp_eop = 1'b0;
    endtask

    task automatic send_tlp(input logic [127:0] h, input logic [63:0] d, input int nb,
                            input bit en, input int bound, output bit acc);
        bit a;
        enable = en;
        drive_beat(1'b1, nb == 1, h, d, bound, acc);
        if (acc) begin
            if (ref_hit(en, h, msix_addr) && d[31:0] < (32'd1 << IW)) begin
                sb_q.push_back(IW'(d));
                exp_irq++;
            end else begin
                exp_drop++;
            end
            for (int b = 1; b < nb; b++) begin
                drive_beat(1'b0, b == nb - 1, {$urandom, $urandom, $urandom, $urandom},
                           {$urandom, $urandom}, 1000, a);
                chk("drain_beat_accept", a, 1);
            end
        end
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((sb_q.size() != 0 || irq_tvalid) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, sb_q.size(), 0);
    endtask

    // Monitor: every pop must match the oldest expected vector
    always @(negedge clk) begin
        if (rst_n && irq_tvalid && irq_tready) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_irq: got 0x%0h expected none at %0t", irq_tdata, $time);
            end else begin
                chk("irq_tdata", irq_tdata, sb_q.pop_front());
            end
        end
    end

    // Random backpressure during the random phase
    always @(posedge clk) begin
        if (rand_rdy) begin
            #1 irq_tready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        logic [127:0] h;

        // Reset state
        #3;
        chk("rst_ready", tlp_ready, 0);
        chk("rst_tvalid", irq_tvalid, 0);
        chk_stats("rst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("ready_before_edge", tlp_ready, 0);
        @(posedge clk); #1;
        chk("ready_after_edge", tlp_ready, 1);

        // 3DW match
        msix_addr = 64'hFEE0_0000; irq_tready = 1'b1;
        h = mk_hdr(3'b010, 5'd0, 10'd1, 4'hF, 64'hFEE0_0000);
        send_tlp(h, 64'd5, 1, 1'b1, 100, acc);
        chk("c1_accept", acc, 1);
        @(negedge clk);
        chk("c1_tvalid_latency", irq_tvalid, 1);
        chk("c1_tkeep", irq_tkeep, 2'b11);
        chk("c1_tlast", irq_tlast, 1);
        chk("c1_tid_tdest_tuser", {irq_tid, irq_tdest, irq_tuser}, 0);
        @(posedge clk); #1;
        wait_drain("c1_drain");
        chk_stats("c1");

        // 4DW match and out-of-range vector
        msix_addr = 64'h1_0000_1000;
        h = mk_hdr(3'b011, 5'd0, 10'd1, 4'hF, 64'h1_0000_1000);
        send_tlp(h, 64'h7FF, 1, 1'b1, 100, acc);
        wait_drain("c2_drain");
        h = mk_hdr(3'b011, 5'd0, 10'd1, 4'hF, 64'h1_0000_1000);
        send_tlp(h, 64'h800, 1, 1'b1, 100, acc);
        repeat (3) begin @(posedge clk); #1; end
        chk("c2_no_output", irq_tvalid, 0);
        chk_stats("c2");

        // Filter mismatches, two-beat drain, stray beat
        msix_addr = 64'hFEE0_0000;
        send_tlp(mk_hdr(3'b010, 5'd0, 10'd1, 4'hF, 64'hFEE0_0004), 64'd1, 1, 1'b1, 100, acc);
        send_tlp(mk_hdr(3'b010, 5'd0, 10'd1, 4'h3, 64'hFEE0_0000), 64'd2, 1, 1'b1, 100, acc);
        send_tlp(mk_hdr(3'b010, 5'd0, 10'd2, 4'hF, 64'hFEE0_0000), 64'd3, 2, 1'b1, 100, acc);
        drive_beat(1'b0, 1'b1, '0, 64'd7, 100, acc);
        chk("c3_stray_consumed", acc, 1);
        send_tlp(mk_hdr(3'b010, 5'd0, 10'd1, 4'hF, 64'hFEE0_0000), 64'd4, 1, 1'b0, 100, acc);
        chk("c3_idle_after_drain", acc, 1);
        repeat (2) begin @(posedge clk); #1; end
        chk("c3_no_tvalid", irq_tvalid, 0);
        chk_stats("c3");

        // Backpressure: FIFO fills, sink stalls, order preserved
        enable = 1'b1; irq_tready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_tlp(mk_hdr(3'b010, 5'd0, 10'd1, 4'hF, 64'hFEE0_0000), 64'(i), 1, 1'b1, 100, acc);
            chk("c4_accept", acc, 1);
        end
        @(negedge clk);
        chk("c4_ready_low_full", tlp_ready, 0);
        @(posedge clk); #1;
        send_tlp(mk_hdr(3'b010, 5'd0, 10'd1, 4'hF, 64'hFEE0_0000), 64'd4, 1, 1'b1, 8, acc);
        chk("c4_stalled", acc, 0);
        irq_tready = 1'b1;
        for (int i = 4; i < 6; i++) begin
            send_tlp(mk_hdr(3'b010, 5'd0, 10'd1, 4'hF, 64'hFEE0_0000), 64'(i), 1, 1'b1, 100, acc);
            chk("c4_accept_after_release", acc, 1);
        end
        wait_drain("c4_drain");
        chk_stats("c4");

        // Reset mid-TLP with entries queued
        irq_tready = 1'b0;
        for (int i = 1; i <= 3; i++)
            send_tlp(mk_hdr(3'b010, 5'd0, 10'd1, 4'hF, 64'hFEE0_0000), 64'(i), 1, 1'b1, 100, acc);
        drive_beat(1'b1, 1'b0, mk_hdr(3'b010, 5'd0, 10'd2, 4'hF, 64'hFEE0_0000), 64'd8, 100, acc);
        chk("c5_in_drain", acc, 1);
        rst_n = 1'b0;
        #1;
        chk("c5_tvalid_async", irq_tvalid, 0);
        chk("c5_ready_async", tlp_ready, 0);
        sb_q.delete();
        exp_irq = 0; exp_drop = 0;
        chk_stats("c5_rst");
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1; irq_tready = 1'b1;
        @(negedge clk);
        chk("c5_ready_after_release", tlp_ready, 0);
        @(posedge clk); #1;
        send_tlp(mk_hdr(3'b010, 5'd0, 10'd1, 4'hF, 64'hFEE0_0000), 64'd9, 1, 1'b1, 100, acc);
        wait_drain("c5_drain");
        chk_stats("c5");

        // Randomized traffic against the reference decode
        rand_rdy = 1;
        for (int t = 0; t < 250; t++) begin
            logic [63:0] a;
            logic [63:0] d;
            logic [2:0]  fmt;
            logic [4:0]  ty;
            logic [9:0]  len;
            logic [3:0]  be;
            int          r;
            if ($urandom_range(0, 15) == 0)
                msix_addr = $urandom_range(0, 1) ? {32'h0, $urandom} : {$urandom, $urandom};
            a   = msix_addr;
            fmt = (a[63:32] == 0 && $urandom_range(0, 1) == 1) ? 3'b010 : 3'b011;
            ty  = 5'd0; len = 10'd1; be = 4'hF;
            r   = $urandom_range(0, 9);
            case (r)
                6: a = a ^ (64'h4 << $urandom_range(0, 29));
                7: be = 4'($urandom);
                8: len = 10'($urandom);
                9: begin fmt = 3'($urandom); ty = 5'($urandom_range(0, 1)); end
                default: ;
            endcase
            d = {$urandom, ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 2047))};
            if ($urandom_range(0, 7) == 0) drive_beat(1'b0, 1'b1, '0, '0, 2000, acc);
            send_tlp(mk_hdr(fmt, ty, len, be, a), d, $urandom_range(1, 3),
                     $urandom_range(0, 9) != 0, 2000, acc);
            chk("rand_accept", acc, 1);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        rand_rdy = 0;
        @(posedge clk); #2;
        irq_tready = 1'b1;
        wait_drain("rand_drain");
        chk_stats("rand");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
